wave_conditioner: RTL and testbench

WAVE_CONDITIONER -- requirements
Module: wave_conditioner

---
 rtl/wave_conditioner.sv | 128 ++++++++++++
 tb/tb_wave_conditioner.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_conditioner.sv
// wave_conditioner: synchronizes an asynchronous waveform, rejects pulses shorter
// than FILT_LEN cycles, strobes accepted edges, counts rejected glitches and
// optionally flags loss of signal.
//
// Ports:
//   clk         rising-edge system clock; all state is clocked here
//   rst_n       asynchronous active-low reset
//   wave        raw external waveform, asynchronous to clk
//   glitch_clr  synchronous clear of glitch_cnt (wins over a same-cycle glitch)
//   wave_clean  synchronized, deglitched level (registered)
//   rise_pulse  one-cycle strobe on an accepted 0->1 transition (registered)
//   fall_pulse  one-cycle strobe on an accepted 1->0 transition (registered)
//   glitch_cnt  saturating count of rejected pulses (registered)
//   no_signal   no accepted edge for TIMEOUT_CYC cycles (registered)
//
// Optional feature: define WAVE_TIMEOUT_EN to build the loss-of-signal timer.
// Without it no_signal is tied low and everything else behaves identically.
//
// Latency: a level held from before edge 1 appears on wave_clean and its strobe
// at edge FILT_LEN+2 (two synchronizer stages plus FILT_LEN filter cycles).

module wave_conditioner #(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wave,
  input  logic       glitch_clr,
  output logic       wave_clean,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [7:0] glitch_cnt,
  output logic       no_signal
);

  localparam logic [7:0]  FILT_MAX = 8'(FILT_LEN - 1);
  localparam logic [23:0] TO_MAX   = 24'(TIMEOUT_CYC);

  logic       s1;
  logic       s2;
  logic [7:0] filt_cnt;
  logic       differ;
  logic       accept;
  logic       glitch;

  // s2 is the only view of the raw waveform used by the filter.
  assign differ = (s2 != wave_clean);
  // filt_cnt counts cycles the new level has already held; on the FILT_LEN-th
  // consecutive differing cycle the new level is taken.
  assign accept = differ && (filt_cnt == FILT_MAX);
  // The level fell back before acceptance after at least one qualifying cycle.
  assign glitch = !differ && (filt_cnt != 8'd0);

  // Two-flop synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= wave;
      s2 <= s1;
    end
  end

  // Symmetric deglitch filter: the same rule applies to both directions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt   <= 8'd0;
      wave_clean <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      if (accept) begin
        wave_clean <= s2;
        filt_cnt   <= 8'd0;
        rise_pulse <= s2;
        fall_pulse <= ~s2;
      end else if (differ) begin
        filt_cnt <= filt_cnt + 8'd1;
      end else begin
        filt_cnt <= 8'd0;
      end
    end
  end

  // Rejected-pulse counter, saturating at 255; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= 8'd0;
    end else if (glitch_clr) begin
      glitch_cnt <= 8'd0;
    end else if (glitch && (glitch_cnt != 8'hFF)) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end
  end

`ifdef WAVE_TIMEOUT_EN
  logic [23:0] to_cnt;

  // to_cnt counts cycles since the last accepted edge and parks at TO_MAX.
  // no_signal rises on the edge that brings to_cnt to TO_MAX and falls on the
  // edge that produces the next strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt    <= 24'd0;
      no_signal <= 1'b0;
    end else if (accept) begin
      to_cnt    <= 24'd0;
      no_signal <= 1'b0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + 24'd1;
      if (to_cnt == TO_MAX - 24'd1) begin
        no_signal <= 1'b1;
      end
    end
  end
`else
  // Timer not built: keep the timeout parameter referenced so both builds
  // elaborate the same parameter set.
  logic unused_timeout;
  assign unused_timeout = ^TO_MAX;
  assign no_signal      = 1'b0;
`endif

endmodule

// File: tb/tb_wave_conditioner.sv
// tb_wave_conditioner: directed bench for wave_conditioner.
// Instance 0 uses FILT_LEN=4, instance 1 uses FILT_LEN=1, both TIMEOUT_CYC=100.
// A run-length model predicts every output each cycle; literal checks pin it.

module tb_wave_conditioner;

  localparam int T_CYC = 100;

  logic       clk;
  logic       rst_n;
  logic [1:0] wv;
  logic [1:0] gc;
  logic [1:0] clean;
  logic [1:0] rise;
  logic [1:0] fall;
  logic [1:0] ns;
  logic [7:0] gcnt_a;
  logic [7:0] gcnt_b;

  int checks   = 0;
  int failures = 0;

  wave_conditioner #(.FILT_LEN(4), .TIMEOUT_CYC(T_CYC)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .wave       (wv[0]),
    .glitch_clr (gc[0]),
    .wave_clean (clean[0]),
    .rise_pulse (rise[0]),
    .fall_pulse (fall[0]),
    .glitch_cnt (gcnt_a),
    .no_signal  (ns[0])
  );

  wave_conditioner #(.FILT_LEN(1), .TIMEOUT_CYC(T_CYC)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .wave       (wv[1]),
    .glitch_clr (gc[1]),
    .wave_clean (clean[1]),
    .rise_pulse (rise[1]),
    .fall_pulse (fall[1]),
    .glitch_cnt (gcnt_b),
    .no_signal  (ns[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef WAVE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Wave as seen by the filter is the input sampled two edges earlier. A new
  // level is accepted once it has been seen on FILT_LEN consecutive edges; a
  // run that ends early is a glitch. idle counts edges since the last accept.
  int flen[2] = '{4, 1};
  bit d1[2], d2[2], m_clean[2], m_rise[2], m_fall[2], m_ns[2];
  int run[2], m_gcnt[2], idle[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        d1[i] = 0; d2[i] = 0; m_clean[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
        m_ns[i] = 0; run[i] = 0; m_gcnt[i] = 0; idle[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit ws, acc, glt;
        ws = d2[i]; d2[i] = d1[i]; d1[i] = wv[i];
        acc = 0; glt = 0;
        m_rise[i] = 0; m_fall[i] = 0;
        if (ws != m_clean[i]) begin
          run[i]++;
          if (run[i] == flen[i]) begin
            acc = 1; run[i] = 0; m_clean[i] = ws;
            if (ws) m_rise[i] = 1; else m_fall[i] = 1;
          end
        end else begin
          glt = (run[i] > 0);
          run[i] = 0;
        end
        if (gc[i]) m_gcnt[i] = 0;
        else if (glt && m_gcnt[i] < 255) m_gcnt[i]++;
        if (acc) idle[i] = 0;
        else if (idle[i] < T_CYC) idle[i]++;
        m_ns[i] = TO_EN && (idle[i] == T_CYC);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("cyc%0d_wave_clean", i), int'(clean[i]), int'(m_clean[i]));
      chk($sformatf("cyc%0d_rise_pulse", i), int'(rise[i]), int'(m_rise[i]));
      chk($sformatf("cyc%0d_fall_pulse", i), int'(fall[i]), int'(m_fall[i]));
      chk($sformatf("cyc%0d_glitch_cnt", i), (i == 0) ? int'(gcnt_a) : int'(gcnt_b), m_gcnt[i]);
      chk($sformatf("cyc%0d_no_signal", i), int'(ns[i]), int'(m_ns[i]));
      chk($sformatf("cyc%0d_no_double_strobe", i), int'(rise[i] & fall[i]), 0);
    end
  end

  // ---------------- directed sequence ----------------
  int tk;
  int rcnt[2], fcnt[2], rfirst[2], ffirst[2];

  task automatic mark();
    tk = 0;
    for (int i = 0; i < 2; i++) begin
      rcnt[i] = 0; fcnt[i] = 0; rfirst[i] = -1; ffirst[i] = -1;
    end
  endtask

  // Advance n edges, sampling 1 time unit after each, logging strobes.
  task automatic advance(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      tk++;
      for (int i = 0; i < 2; i++) begin
        if (rise[i]) begin rcnt[i]++; if (rfirst[i] < 0) rfirst[i] = tk; end
        if (fall[i]) begin fcnt[i]++; if (ffirst[i] < 0) ffirst[i] = tk; end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; wv = 2'b00; gc = 2'b00;
    mark();
    advance(3);
    chk("reset_wave_clean", int'(clean[0]), 0);
    chk("reset_glitch_cnt", int'(gcnt_a), 0);
    chk("reset_no_signal", int'(ns[0]), 0);
    rst_n = 1'b1;
    advance(2);

    // 3-cycle pulse is rejected.
    mark();
    wv[0] = 1'b1; advance(3); wv[0] = 1'b0; advance(10);
    chk("glitch3_no_rise", rcnt[0], 0);
    chk("glitch3_clean", int'(clean[0]), 0);
    chk("glitch3_cnt", int'(gcnt_a), 1);

    // 4-cycle pulse is accepted; rise at edge 6, fall at edge 4+6.
    mark();
    wv[0] = 1'b1; advance(4); wv[0] = 1'b0; advance(12);
    chk("pulse4_rise_edge", rfirst[0], 6);
    chk("pulse4_fall_edge", ffirst[0], 10);
    chk("pulse4_rise_count", rcnt[0], 1);

    // Clear, then a held level: rise exactly once at edge 6.
    gc[0] = 1'b1; advance(1); gc[0] = 1'b0;
    chk("clr_glitch_cnt", int'(gcnt_a), 0);
    mark();
    wv[0] = 1'b1; advance(20);
    chk("held_rise_edge", rfirst[0], 6);
    chk("held_rise_count", rcnt[0], 1);
    chk("held_clean", int'(clean[0]), 1);
    chk("held_glitch_cnt", int'(gcnt_a), 0);

    // Timeout: 100 edges after the strobe at edge 6.
    advance(85);
    chk("timeout_edge99", int'(ns[0]), 0);
    advance(1);
    chk("timeout_edge100", int'(ns[0]), TO_EN ? 1 : 0);
    mark();
    wv[0] = 1'b0; advance(5);
    chk("timeout_held", int'(ns[0]), TO_EN ? 1 : 0);
    advance(1);
    chk("timeout_release_fall", int'(fall[0]), 1);
    chk("timeout_release_ns", int'(ns[0]), 0);
    advance(4);

    // Saturation after 300 rejected pulses.
    for (int g = 0; g < 300; g++) begin
      wv[0] = 1'b1; advance(3); wv[0] = 1'b0; advance(5);
    end
    chk("sat_glitch_cnt", int'(gcnt_a), 255);
    chk("sat_clean", int'(clean[0]), 0);

    // Clear coincides with the edge that detects a glitch (edge 6).
    wv[0] = 1'b1; advance(3); wv[0] = 1'b0; advance(2);
    gc[0] = 1'b1; advance(1); gc[0] = 1'b0;
    chk("clr_vs_glitch", int'(gcnt_a), 0);
    advance(3);
    chk("clr_vs_glitch_after", int'(gcnt_a), 0);

    // Reset mid-filter: build clean=1 and a glitch count, start a fall.
    wv[0] = 1'b1; advance(3); wv[0] = 1'b0; advance(5);
    wv[0] = 1'b1; advance(12);
    chk("pre_reset_clean", int'(clean[0]), 1);
    chk("pre_reset_gcnt", int'(gcnt_a), 1);
    wv[0] = 1'b0; advance(4);
    #2 rst_n = 1'b0; wv[0] = 1'b1;
    #1;
    chk("midrst_clean", int'(clean[0]), 0);
    chk("midrst_rise", int'(rise[0]), 0);
    chk("midrst_fall", int'(fall[0]), 0);
    chk("midrst_gcnt", int'(gcnt_a), 0);
    chk("midrst_ns", int'(ns[0]), 0);
    advance(2);
    mark();
    rst_n = 1'b1;
    advance(8);
    chk("post_reset_rise_edge", rfirst[0], 6);
    chk("post_reset_rise_count", rcnt[0], 1);

    // FILT_LEN=1 square wave, 5 high / 5 low, four periods.
    mark();
    for (int p = 0; p < 4; p++) begin
      wv[1] = 1'b1; advance(5); wv[1] = 1'b0; advance(5);
    end
    advance(5);
    chk("sq_first_rise_edge", rfirst[1], 3);
    chk("sq_first_fall_edge", ffirst[1], 8);
    chk("sq_rise_count", rcnt[1], 4);
    chk("sq_fall_count", fcnt[1], 4);
    chk("sq_glitch_cnt", int'(gcnt_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
